// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV64M multiply/divide unit.
//   - funct3 encodings MD_MUL..MD_REMU
//   - FSM state enum and the datapath step mode
//   - iteration counts for doubleword (N_D) and word (N_W) operations
//   - sext32: sign-extend a 32-bit value to 64 bits (W-suffix results)
package muldiv_pkg;

  localparam int N_D = 64;
  localparam int N_W = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   start/op/word/src1/src2/flush : requester -> unit
//   busy/done/result              : unit -> requester
// master modport is the pipeline side, slave modport is the unit side.
interface muldiv_if;

  logic        start;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] result;

  modport master (
    output start, op, word, src1, src2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, word, src1, src2, flush,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared datapath.
//   i_mode : STEP_MUL = radix-2 shift-add, STEP_DIV = restoring divide step
//   i_acc  : product high half / partial remainder
//   i_part : multiplier shifting out with product bits shifting in /
//            dividend shifting out with quotient bits shifting in
//   i_opnd : multiplicand / divisor magnitude
//   o_acc, o_part : register values for the next cycle
module muldiv_step
  import muldiv_pkg::*;
(
  input  step_mode_e  i_mode,
  input  logic [63:0] i_acc,
  input  logic [63:0] i_part,
  input  logic [63:0] i_opnd,
  output logic [63:0] o_acc,
  output logic [63:0] o_part
);

  logic [64:0] w_sum;
  logic [64:0] w_shift;
  logic [64:0] w_diff;

  // Single multiply or divide iteration selected by mode.
  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_part[0] ? {1'b0, i_opnd} : 65'd0);
    // Partial remainder is always below the divisor, so the shifted value
    // fits in 65 bits and bit 64 of the difference is a valid sign.
    w_shift = {i_acc, i_part[63]};
    w_diff  = w_shift - {1'b0, i_opnd};
    o_acc   = i_acc;
    o_part  = i_part;
    case (i_mode)
      STEP_MUL: begin
        o_acc  = w_sum[64:1];
        o_part = {w_sum[0], i_part[63:1]};
      end
      STEP_DIV: begin
        if (!w_diff[64]) begin
          o_acc  = w_diff[63:0];
          o_part = {i_part[62:0], 1'b1};
        end else begin
          o_acc  = w_shift[63:0];
          o_part = {i_part[62:0], 1'b0};
        end
      end
      default: begin
        o_acc  = i_acc;
        o_part = i_part;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide (MUL..REMU plus W variants).
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : muldiv_if.slave -- start/op/word/src1/src2/flush in,
//            busy/done/result out (all outputs registered)
// Operands are reduced to magnitudes when accepted; N iterations of
// muldiv_step run in CALC, FIX applies the sign and selects the result.
// Divide-by-zero and signed overflow finish straight from IDLE/DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [2:0]       r_op;
  logic             r_word;
  logic             r_neg;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_part;
  logic [XLEN-1:0]  r_opnd;
  logic [XLEN-1:0]  r_result;
  logic [6:0]       r_count;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_is_div;
  logic             w_word_sx;
  logic [XLEN-1:0]  w_a_ext;
  logic [XLEN-1:0]  w_b_ext;
  logic             w_a_sgn;
  logic             w_b_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_fast;
  logic             w_neg;
  logic [XLEN-1:0]  w_fast_res;
  logic [XLEN-1:0]  w_load_part;
  logic [XLEN-1:0]  w_load_opnd;
  step_mode_e       w_mode;
  logic [XLEN-1:0]  w_step_acc;
  logic [XLEN-1:0]  w_step_part;
  logic [127:0]     w_prod;
  logic [127:0]     w_prod_s;
  logic [XLEN-1:0]  w_quo;
  logic [XLEN-1:0]  w_quo_s;
  logic [XLEN-1:0]  w_rem_s;
  logic [XLEN-1:0]  w_dv;
  logic [XLEN-1:0]  w_fix_res;
  logic [XLEN-1:0]  w_result_nxt;

  // Operand extension, magnitudes, sign flag and fast-path detection.
  always_comb begin
    w_is_div  = bus.op[2];
    // Only DIVW/REMW treat the low word as signed; MULW needs only the
    // low 32 product bits, which are identical for any signedness.
    w_word_sx = bus.word & bus.op[2] & ~bus.op[0];
    if (bus.word) begin
      if (w_word_sx) begin
        w_a_ext = sext32(bus.src1[31:0]);
        w_b_ext = sext32(bus.src2[31:0]);
      end else begin
        w_a_ext = {32'd0, bus.src1[31:0]};
        w_b_ext = {32'd0, bus.src2[31:0]};
      end
      w_a_sgn = w_word_sx;
      w_b_sgn = w_word_sx;
    end else begin
      w_a_ext = bus.src1;
      w_b_ext = bus.src2;
      w_a_sgn = (bus.op == MD_MULH) | (bus.op == MD_MULHSU) |
                (bus.op == MD_DIV)  | (bus.op == MD_REM);
      w_b_sgn = (bus.op == MD_MULH) | (bus.op == MD_DIV) | (bus.op == MD_REM);
    end
    w_a_neg = w_a_sgn & w_a_ext[63];
    w_b_neg = w_b_sgn & w_b_ext[63];
    if (w_a_neg) begin
      w_a_mag = ~w_a_ext + 64'd1;
    end else begin
      w_a_mag = w_a_ext;
    end
    if (w_b_neg) begin
      w_b_mag = ~w_b_ext + 64'd1;
    end else begin
      w_b_mag = w_b_ext;
    end
    // Remainder sign follows the dividend, everything else is the XOR.
    if (w_is_div & bus.op[1]) begin
      w_neg = w_a_neg;
    end else begin
      w_neg = w_a_neg ^ w_b_neg;
    end
    w_div_zero = w_is_div & (w_b_ext == 64'd0);
    w_ovf      = w_is_div & ~bus.op[0] & (w_b_ext == {64{1'b1}}) &
                 (w_a_ext == (bus.word ? 64'hFFFF_FFFF_8000_0000
                                       : 64'h8000_0000_0000_0000));
    w_fast     = w_div_zero | w_ovf;
    if (w_div_zero) begin
      if (bus.op[1]) begin
        w_fast_res = bus.word ? sext32(bus.src1[31:0]) : bus.src1;
      end else begin
        w_fast_res = {64{1'b1}};
      end
    end else begin
      w_fast_res = bus.op[1] ? 64'd0 : w_a_ext;
    end
    // Word divides start with the 32-bit dividend in the top half so its
    // MSB is the first bit shifted into the remainder.
    if (w_is_div) begin
      w_load_part = bus.word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
      w_load_opnd = w_b_mag;
    end else begin
      w_load_part = w_b_mag;
      w_load_opnd = w_a_mag;
    end
  end

  // Next-state logic and next values of the registered status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start && !bus.flush) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fast ? ST_DONE : ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == 7'd1) begin
          w_state_nxt = ST_FIX;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_CALC) | (w_state_nxt == ST_FIX);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Datapath mode follows the latched funct3.
  always_comb begin
    if (r_op[2]) begin
      w_mode = STEP_DIV;
    end else begin
      w_mode = STEP_MUL;
    end
  end

  muldiv_step u_step (
    .i_mode (w_mode),
    .i_acc  (r_acc),
    .i_part (r_part),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc),
    .o_part (w_step_part)
  );

  // Sign correction and result selection for the FIX state.
  always_comb begin
    w_prod = {r_acc, r_part};
    if (r_neg) begin
      w_prod_s = ~w_prod + 128'd1;
    end else begin
      w_prod_s = w_prod;
    end
    w_quo = r_word ? {32'd0, r_part[31:0]} : r_part;
    if (r_neg) begin
      w_quo_s = ~w_quo + 64'd1;
      w_rem_s = ~r_acc + 64'd1;
    end else begin
      w_quo_s = w_quo;
      w_rem_s = r_acc;
    end
    w_dv = r_op[1] ? w_rem_s : w_quo_s;
    if (!r_op[2]) begin
      // After 32 word-mode steps the low product word sits in r_part[63:32].
      if (r_word) begin
        w_fix_res = sext32(r_part[63:32]);
      end else if (r_op == MD_MUL) begin
        w_fix_res = w_prod_s[63:0];
      end else begin
        w_fix_res = w_prod_s[127:64];
      end
    end else begin
      if (r_word) begin
        w_fix_res = sext32(w_dv[31:0]);
      end else begin
        w_fix_res = w_dv;
      end
    end
    if (w_accept && w_fast) begin
      w_result_nxt = w_fast_res;
    end else if ((r_state == ST_FIX) && !bus.flush) begin
      w_result_nxt = w_fix_res;
    end else begin
      w_result_nxt = r_result;
    end
  end

  // State register and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 64'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Operation latch on accept, one datapath iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= 3'd0;
      r_word  <= 1'b0;
      r_neg   <= 1'b0;
      r_acc   <= 64'd0;
      r_part  <= 64'd0;
      r_opnd  <= 64'd0;
      r_count <= 7'd0;
    end else if (w_accept) begin
      r_op    <= bus.op;
      r_word  <= bus.word;
      r_neg   <= w_neg;
      r_acc   <= 64'd0;
      r_part  <= w_load_part;
      r_opnd  <= w_load_opnd;
      r_count <= bus.word ? 7'(N_W) : 7'(N_D);
    end else if (r_state == ST_CALC) begin
      r_acc   <= w_step_acc;
      r_part  <= w_step_part;
      r_count <= r_count - 7'd1;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Each issued operation
// pushes a reference result; the value is popped and compared at done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  muldiv_if bus();

  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [31:0] r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    logic signed [127:0] pa, pb, pp;
    logic [127:0] up;
    logic ovf32, ovf64;
    r = 64'd0; r32 = 32'd0;
    sa32 = a[31:0]; sb32 = b[31:0]; sa64 = a; sb64 = b;
    up = {64'd0, a} * {64'd0, b};
    pa = {{64{a[63]}}, a};
    pb = {{64{b[63]}}, b};
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (w) begin
      case (op)
        3'b100: if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF; else if (ovf32) r32 = a[31:0]; else r32 = sa32 / sb32;
        3'b101: if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF; else r32 = a[31:0] / b[31:0];
        3'b110: if (b[31:0] == 32'd0) r32 = a[31:0]; else if (ovf32) r32 = 32'd0; else r32 = sa32 % sb32;
        3'b111: if (b[31:0] == 32'd0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        3'b000: r = up[63:0];
        3'b001: begin pp = pa * pb; r = pp[127:64]; end
        3'b010: begin pb = {64'd0, b}; pp = pa * pb; r = pp[127:64]; end
        3'b011: r = up[127:64];
        3'b100: if (b == 64'd0) r = {64{1'b1}}; else if (ovf64) r = a; else r = sa64 / sb64;
        3'b101: if (b == 64'd0) r = {64{1'b1}}; else r = a / b;
        3'b110: if (b == 64'd0) r = a; else if (ovf64) r = 64'd0; else r = sa64 % sb64;
        default: if (b == 64'd0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (op[2]) begin
      if (w && b[31:0] == 32'd0) return 1;
      if (!w && b == 64'd0) return 1;
      if (!op[0] && w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      if (!op[0] && !w && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return 1;
    end
    return w ? 34 : 66;
  endfunction

  // Drive start for the current cycle; operands are scrambled afterwards.
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.start = 1'b1; bus.op = op; bus.word = w; bus.src1 = a; bus.src2 = b;
    sb_q.push_back(ref_md(op, w, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src1 = {$urandom, $urandom};
    bus.src2 = {$urandom, $urandom};
    bus.op = 3'($urandom);
    bus.word = 1'($urandom);
  endtask

  // Count cycles (first is cycle 1) until done, with a bounded wait.
  task automatic wait_done(output int lat, output int busy_cnt, output bit busy_at_done, output bit timed_out);
    int c;
    lat = 0; busy_cnt = 0; busy_at_done = 1'b0; timed_out = 1'b1; c = 0;
    while (timed_out && c < 200) begin
      c++;
      @(negedge clk);
      if (bus.done) begin
        lat = c; busy_at_done = bus.busy; timed_out = 1'b0;
      end else if (bus.busy) begin
        busy_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 64'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.result); end
    last_res = 64'd0;
  endtask

  // Directed cases with spec constants: multiply, fast paths, word divide.
  task automatic test_directed();
    logic [2:0] ops[10];
    logic ws[10];
    logic [63:0] av[10], bv[10], ev[10];
    int lats[10];
    int lat, bc; bit bad, tmo;
    logic [63:0] exp;
    ops = '{MD_MUL, MD_MULHU, MD_MULH, MD_DIV, MD_REM, MD_DIV, MD_REM, MD_DIV, MD_REM, MD_REMU};
    ws  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    av  = '{64'd7, {64{1'b1}}, {64{1'b1}}, 64'd100, 64'd100, 64'h8000_0000_0000_0000,
            64'h8000_0000_0000_0000, 64'h0000_0001_FFFF_FFF9, 64'h0000_0001_FFFF_FFF9, 64'h0000_0000_8000_0005};
    bv  = '{64'hFFFF_FFFF_FFFF_FFFD, {64{1'b1}}, {64{1'b1}}, 64'd0, 64'd0, {64{1'b1}},
            {64{1'b1}}, 64'd2, 64'd2, 64'hFFFF_FFFF_0000_0000};
    ev  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, {64{1'b1}}, 64'd100,
            64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, {64{1'b1}}, 64'hFFFF_FFFF_8000_0005};
    lats = '{66, 66, 66, 1, 1, 1, 1, 34, 34, 1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(ops[i], ws[i], av[i], bv[i]);
      wait_done(lat, bc, bad, tmo);
      n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL dir%0d_timeout no done within bound", i); end
      n_cmp++; if (lat !== lats[i]) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lats[i]); end
      n_cmp++; if (bc !== lats[i] - 1) begin n_bad++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, lats[i] - 1); end
      n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_at_done got %b want 0", i, bad); end
      n_cmp++; if (bus.result !== ev[i]) begin n_bad++; $display("FAIL dir%0d_const got %h want %h", i, bus.result, ev[i]); end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      n_cmp++; if (bus.result !== exp) begin n_bad++; $display("FAIL dir%0d_model got %h want %h", i, bus.result, exp); end
      last_res = exp;
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse got %b want 0", i, bus.done); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic w; logic [63:0] a, b, exp;
    int lat, bc, el; bit bad, tmo;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom); w = 1'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 200));
      el = exp_lat(op, w, a, b);
      @(negedge clk);
      issue(op, w, a, b);
      wait_done(lat, bc, bad, tmo);
      n_cmp++; if (lat !== el) begin n_bad++; $display("FAIL rnd%0d_latency op=%0d w=%0d got %0d want %0d", i, op, w, lat, el); end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      n_cmp++; if (bus.result !== exp) begin n_bad++; $display("FAIL rnd%0d_result op=%0d w=%0d a=%h b=%h got %h want %h", i, op, w, a, b, bus.result, exp); end
      last_res = exp;
    end
  endtask

  task automatic test_flush();
    int lat, bc, ndone; bit bad, tmo;
    logic [63:0] exp;
    @(negedge clk);
    issue(MD_MUL, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before got %b want 1", bus.busy); end
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = MD_DIV; bus.word = 1'b0;
    bus.src1 = 64'd50; bus.src2 = 64'd0;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after got %b want 0", bus.busy); end
    ndone = (bus.done === 1'b1) ? 1 : 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL flush_no_done got %0d pulses want 0", ndone); end
    n_cmp++; if (bus.result !== last_res) begin n_bad++; $display("FAIL flush_result_held got %h want %h", bus.result, last_res); end
    @(negedge clk);
    issue(MD_MUL, 1'b0, 64'd3, 64'd5);
    wait_done(lat, bc, bad, tmo);
    n_cmp++; if (lat !== 66) begin n_bad++; $display("FAIL restart_latency got %0d want 66", lat); end
    n_cmp++; if (bus.result !== 64'd15) begin n_bad++; $display("FAIL restart_result got %h want %h", bus.result, 64'd15); end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    n_cmp++; if (bus.result !== exp) begin n_bad++; $display("FAIL restart_model got %h want %h", bus.result, exp); end
    last_res = exp;
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    issue(MD_DIV, 1'b0, 64'd1000, 64'd7);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 64'd0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", bus.result); end
    last_res = 64'd0;
    ndone = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d pulses want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit bad, tmo;
    logic [63:0] exp;
    @(negedge clk);
    issue(MD_MULHU, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0003);
    wait_done(lat, bc, bad, tmo);
    n_cmp++; if (lat !== 66) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 66", lat); end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    n_cmp++; if (bus.result !== exp) begin n_bad++; $display("FAIL b2b_first_result got %h want %h", bus.result, exp); end
    // Still inside the DONE cycle: start the next op immediately.
    issue(MD_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    wait_done(lat, bc, bad, tmo);
    n_cmp++; if (lat !== 66) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 66", lat); end
    n_cmp++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL b2b_second_const got %h want %h", bus.result, 64'hFFFF_FFFF_FFFF_FFFE); end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    n_cmp++; if (bus.result !== exp) begin n_bad++; $display("FAIL b2b_second_model got %h want %h", bus.result, exp); end
    last_res = exp;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.word = 1'b0;
    bus.src1 = 64'd0; bus.src2 = 64'd0;
    last_res = 64'd0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
